// File: rtl/fifo_arb_pkg.sv
// Shared defaults and the round-robin search helper for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned NREQ_DEFAULT  = 4;
  localparam int unsigned DW_DEFAULT    = 8;
  localparam int unsigned DEPTH_DEFAULT = 16;
  localparam int unsigned AW_DEFAULT    = 4;

  // Widest requester vector rr_next understands; NREQ may be 2..8.
  localparam int unsigned MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Search last+1, last+2, ... modulo nreq; return the first requesting index.
  function automatic rr_pick_t rr_next(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0]         last,
                                       input int unsigned        nreq);
    rr_pick_t    pick;
    int unsigned cand;
    logic [2:0]  cand3;
    pick = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      cand  = (32'(last) + k) % nreq;
      cand3 = cand[2:0];
      if (k <= nreq && !pick.found && req[cand3]) begin
        pick.found = 1'b1;
        pick.idx   = cand3;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_rr_grant.sv
// Combinational round-robin grant: one-hot gnt plus its index, suppressed by hold.
module fifo_rr_grant
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  localparam int unsigned LW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  input  logic            hold,
  output logic [NREQ-1:0] gnt,
  output logic [LW-1:0]   gnt_idx
);

  rr_pick_t pick;
  logic     unused_pick;

  assign unused_pick = ^pick.idx;

  // Pick the next requester after last; hold (full or reset) blocks every grant.
  always_comb begin
    pick    = rr_next(MAX_REQ'(req), 3'(last), NREQ);
    gnt_idx = pick.idx[LW-1:0];
    gnt     = '0;
    if (pick.found && !hold) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_rr_wr_arbiter.sv
// Shared 16x8 FIFO fed by NREQ round-robin-arbitrated producers, drained by one consumer.
// Optional sticky ovf_err/unf_err outputs are built when FIFO_ARB_ERR_FLAGS_EN is defined.
module fifo_rr_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  localparam int unsigned LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  input  logic              rd_en,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count
`ifdef FIFO_ARB_ERR_FLAGS_EN
  ,
  output logic              ovf_err,
  output logic              unf_err
`endif
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [LW-1:0] last_q, gnt_idx;
  logic [DW-1:0] rd_data_q, wr_data;
  logic          rd_valid_q;
  logic          push, pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  fifo_rr_grant #(
    .NREQ (NREQ)
  ) u_grant (
    .req     (req),
    .last    (last_q),
    .hold    (full | rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign push    = |gnt;
  assign pop     = rd_en & ~empty & ~rst;
  assign wr_data = req_data[gnt_idx*DW +: DW];

  // Occupancy next state: push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is never cleared; push is already gated off during reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers, count, round-robin state and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= LW'(NREQ - 1);
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= pop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        last_q   <= gnt_idx;
      end
      if (pop) begin
        rd_data_q <= mem[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
    end
  end

`ifdef FIFO_ARB_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

  // Sticky misuse flags: stall under back-pressure, pop while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (full & (|req));
      unf_q <= unf_q | (rd_en & empty);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Directed, table-driven bench for fifo_rr_wr_arbiter with hand sequences for corners.
module tb_fifo_rr_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [4:0]  count;
`ifdef FIFO_ARB_ERR_FLAGS_EN
  logic        ovf_err;
  logic        unf_err;
`endif

  fifo_rr_wr_arbiter #(
    .NREQ  (4),
    .DW    (8),
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count)
`ifdef FIFO_ARB_ERR_FLAGS_EN
    ,
    .ovf_err  (ovf_err),
    .unf_err  (unf_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        rd_en;
    logic [3:0]  gnt;
    logic [4:0]  cnt;
    logic        emp;
    logic        ful;
    logic        rv;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   row      = 0;

  localparam logic [31:0] DataA = 32'hA3A2A1A0;

  function automatic vec_t mk(logic r, logic [3:0] q, logic [31:0] d, logic re,
                              logic [3:0] g, int c, logic e, logic f, logic v,
                              logic [7:0] rdv);
    vec_t x;
    x.rst = r; x.req = q; x.data = d; x.rd_en = re;
    x.gnt = g; x.cnt = 5'(c); x.emp = e; x.ful = f; x.rv = v; x.rd = rdv;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL row%0d %s: got %0h expected %0h", row, name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then compare 1 ns later.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst      = v.rst;
    req      = v.req;
    req_data = v.data;
    rd_en    = v.rd_en;
    #1;
    chk("gnt",      32'(gnt),      32'(v.gnt));
    chk("count",    32'(count),    32'(v.cnt));
    chk("empty",    32'(empty),    32'(v.emp));
    chk("full",     32'(full),     32'(v.ful));
    chk("rd_valid", 32'(rd_valid), 32'(v.rv));
    chk("rd_data",  32'(rd_data),  32'(v.rd));
    row++;
  endtask

  logic [7:0] q_model[$];
  logic [7:0] m_rd;
  logic       m_rv;
  logic [7:0] popped;
  int         writes;
  logic       do_w, do_r;

  initial begin
    rst = 1'b1; req = '0; req_data = '0; rd_en = 1'b0;

    // Reset state.
    tbl.push_back(mk(1, 4'hF, DataA, 0, 4'h0, 0, 1, 0, 0, 8'h00));
    // All four requesting: grants rotate 0,1,2,3 until full.
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(0, 4'hF, DataA, 0, 4'(1 << (k % 4)), k, k == 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 4'hF, DataA, 0, 4'h0, 16, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 4'hF, DataA, 0, 4'h0, 16, 0, 1, 0, 8'h00));
    // Reset from full discards everything.
    tbl.push_back(mk(1, 4'hF, DataA, 1, 4'h0, 16, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 4'h0, 32'h0, 0, 4'h0, 0, 1, 0, 0, 8'h00));
    // Producer 0 alone writes 0x00..0x0F.
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(0, 4'h1, 32'(k), 0, 4'h1, k, k == 0, 0, 0, 8'h00));
    // Drain with rd_en held; 17th pop hits empty, then rd_data holds.
    for (int j = 0; j < 18; j++)
      tbl.push_back(mk(0, 4'h0, 32'h0, j <= 16, 4'h0, (j <= 16) ? 16 - j : 0,
                       j >= 16, j == 0, (j >= 1) && (j <= 16),
                       (j == 0) ? 8'h00 : ((j <= 16) ? 8'(j - 1) : 8'h0F)));

    foreach (tbl[i]) apply(tbl[i]);

    // Fill to 15 with 0x10..0x1E.
    for (int k = 0; k < 15; k++)
      apply(mk(0, 4'h1, 32'(8'h10 + k), 0, 4'h1, k, k == 0, 0, 0, 8'h0F));
    // Push (producer 2) and pop together at count 15.
    apply(mk(0, 4'h4, 32'h005A0000, 1, 4'h4, 15, 0, 0, 0, 8'h0F));
    apply(mk(0, 4'h1, 32'h0000001F, 0, 4'h1, 15, 0, 0, 1, 8'h10));
    // Full: producer 1 stalls while a pop frees a slot, then is granted.
    apply(mk(0, 4'h2, 32'h00007700, 1, 4'h0, 16, 0, 1, 0, 8'h10));
    apply(mk(0, 4'h2, 32'h00007700, 0, 4'h2, 15, 0, 0, 1, 8'h11));
    apply(mk(0, 4'h0, 32'h0, 0, 4'h0, 16, 0, 1, 0, 8'h11));
    // Pop 9 to reach count 7.
    for (int p = 0; p < 9; p++)
      apply(mk(0, 4'h0, 32'h0, 1, 4'h0, 16 - p, 0, p == 0, p > 0,
               (p == 0) ? 8'h11 : 8'(8'h12 + p - 1)));
    // Reset mid-fill at count 7; rd_en ignored; req[0] wins first afterwards.
    apply(mk(1, 4'hF, DataA, 1, 4'h0, 7, 0, 0, 1, 8'h1A));
    apply(mk(0, 4'hF, DataA, 0, 4'h1, 0, 1, 0, 0, 8'h00));
    apply(mk(1, 4'h0, 32'h0, 0, 4'h0, 1, 0, 0, 0, 8'h00));

    // 20 writes / 20 reads interleaved across the pointer wrap, against a queue.
    q_model.delete();
    m_rv = 1'b0; m_rd = 8'h00; writes = 0;
    for (int c = 0; c < 24; c++) begin
      do_w = (writes < 20);
      do_r = (c >= 2) && (c < 22);
      apply(mk(0, do_w ? 4'h8 : 4'h0, {8'(8'h80 + writes), 24'h0}, do_r,
               (do_w && q_model.size() < 16) ? 4'h8 : 4'h0, q_model.size(),
               q_model.size() == 0, q_model.size() == 16, m_rv, m_rd));
      chk("count_bound", 32'(count <= 5'd16), 32'd1);
      m_rv = 1'b0;
      if (do_r && q_model.size() > 0) begin
        popped = q_model.pop_front();
        m_rd   = popped;
        m_rv   = 1'b1;
      end
      if (do_w && q_model.size() < 16 + (m_rv ? 1 : 0)) begin
        q_model.push_back(8'(8'h80 + writes));
        writes++;
      end
    end
    chk("wrap_writes", 32'(writes), 32'd20);

`ifdef FIFO_ARB_ERR_FLAGS_EN
    apply(mk(1, 4'h0, 32'h0, 0, 4'h0, 0, 1, 0, 0, m_rd));
    apply(mk(0, 4'h0, 32'h0, 1, 4'h0, 0, 1, 0, 0, 8'h00));
    chk("unf_clear", 32'(unf_err), 32'd0);
    apply(mk(0, 4'h0, 32'h0, 0, 4'h0, 0, 1, 0, 0, 8'h00));
    chk("unf_set", 32'(unf_err), 32'd1);
    apply(mk(0, 4'h0, 32'h0, 0, 4'h0, 0, 1, 0, 0, 8'h00));
    chk("unf_sticky", 32'(unf_err), 32'd1);
    chk("ovf_clear", 32'(ovf_err), 32'd0);
    apply(mk(1, 4'h0, 32'h0, 0, 4'h0, 0, 1, 0, 0, 8'h00));
    apply(mk(0, 4'h0, 32'h0, 0, 4'h0, 0, 1, 0, 0, 8'h00));
    chk("unf_rst", 32'(unf_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
